// File: rtl/mmul_parallel_lane_scatter.sv
// Round-robin scatter of one word-serial operand stream into N_LANES lane FIFOs,
// counting accepted words against a programmed length and pulsing done once
// every lane has drained.
module mmul_parallel_lane_scatter #(
    parameter int unsigned N_LANES    = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            start_i,
    input  logic [CNT_WIDTH-1:0]            len_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [DATA_WIDTH-1:0]           in_data_i,
    output logic [N_LANES-1:0]              out_valid_o,
    input  logic [N_LANES-1:0]              out_ready_i,
    output logic [N_LANES*DATA_WIDTH-1:0]   out_data_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [CNT_WIDTH-1:0]            cnt_o
);

    localparam int unsigned LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCATTER = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [LANE_W-1:0]       r_ptr;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    r_len;

    logic [ADDR_W-1:0]       r_wr_ptr [N_LANES];
    logic [ADDR_W-1:0]       r_rd_ptr [N_LANES];
    logic [OCC_W-1:0]        r_occ    [N_LANES];
    logic [DATA_WIDTH-1:0]   r_mem    [N_LANES][FIFO_DEPTH];

    logic [N_LANES-1:0]      w_full;
    logic [N_LANES-1:0]      w_empty;
    logic [N_LANES-1:0]      w_push;
    logic [N_LANES-1:0]      w_pop;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_all_empty;

    // Lane FIFO status flags and lane outputs (head word, zero while empty)
    always_comb begin
        w_full      = '0;
        w_empty     = '0;
        out_valid_o = '0;
        out_data_o  = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            w_full[k]      = (r_occ[k] == OCC_W'(FIFO_DEPTH));
            w_empty[k]     = (r_occ[k] == '0);
            out_valid_o[k] = !w_empty[k];
            out_data_o[k*DATA_WIDTH +: DATA_WIDTH] =
                w_empty[k] ? '0 : r_mem[k][r_rd_ptr[k]];
        end
    end

    assign w_all_empty = &w_empty;
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_last      = ((r_cnt + CNT_WIDTH'(1)) == r_len);
    assign cnt_o       = r_cnt;

    // Per-lane push (steered by the round-robin pointer) and pop strobes
    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            w_push[k] = w_accept && (r_ptr == LANE_W'(k));
            w_pop[k]  = !w_empty[k] && out_ready_i[k];
        end
    end

    // FIFO pointers and occupancy; clear empties every lane
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < N_LANES; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_occ[k]    <= '0;
            end
        end else if (clear_i) begin
            for (int unsigned k = 0; k < N_LANES; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_occ[k]    <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_LANES; k++) begin
                if (w_push[k]) r_wr_ptr[k] <= r_wr_ptr[k] + ADDR_W'(1);
                if (w_pop[k])  r_rd_ptr[k] <= r_rd_ptr[k] + ADDR_W'(1);
                if (w_push[k] && !w_pop[k])      r_occ[k] <= r_occ[k] + OCC_W'(1);
                else if (w_pop[k] && !w_push[k]) r_occ[k] <= r_occ[k] - OCC_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while the lane is empty
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < N_LANES; k++) begin
            if (w_push[k]) r_mem[k][r_wr_ptr[k]] <= in_data_i;
        end
    end

    // Job registers: latched length, accepted-word count, lane pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_len <= '0;
        end else if (clear_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_len <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_len <= len_i;
        end else if (w_accept) begin
            r_ptr <= (r_ptr == LANE_W'(N_LANES - 1)) ? '0 : r_ptr + LANE_W'(1);
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        r_state <= S_IDLE;
        else if (clear_i) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = (len_i == '0) ? S_DONE : S_SCATTER;
            end
            S_SCATTER: begin
                if (w_accept && w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_all_empty) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; ready depends only on registered state, never on in_valid_i
    always_comb begin
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
            end
            S_SCATTER: begin
                busy_o     = 1'b1;
                in_ready_o = !w_full[r_ptr];
            end
            S_DRAIN: begin
                busy_o = 1'b1;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mmul_parallel_lane_scatter.sv
// Scoreboard bench for mmul_parallel_lane_scatter: every accepted input word is
// queued for its round-robin lane and checked against that lane's output.
module tb_mmul_parallel_lane_scatter;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              clear_i;
    logic              start_i;
    logic [CW-1:0]     len_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DW-1:0]     in_data_i;
    logic [N-1:0]      out_valid_o;
    logic [N-1:0]      out_ready_i;
    logic [N*DW-1:0]   out_data_o;
    logic              busy_o;
    logic              done_o;
    logic [CW-1:0]     cnt_o;

    always #5 clk = ~clk;

    mmul_parallel_lane_scatter #(
        .N_LANES(16), .DATA_WIDTH(32), .FIFO_DEPTH(2), .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .len_i(len_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
    );

    logic [DW-1:0] exp_q [N][$];
    logic [DW-1:0] mon_exp;
    int n_cmp  = 0;
    int n_fail = 0;
    int cur_idx = 0;
    int lane_m  = 0;

    // Scoreboard: every lane handshake must deliver the oldest word queued for that lane
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (out_valid_o[k] && out_ready_i[k]) begin
                n_cmp++;
                if (exp_q[k].size() == 0) begin
                    n_fail++;
                    $display("FAIL lane%0d_word: got %0h, required no word", k, out_data_o[k*DW +: DW]);
                end else begin
                    mon_exp = exp_q[k].pop_front();
                    if (out_data_o[k*DW +: DW] !== mon_exp) begin
                        n_fail++;
                        $display("FAIL lane%0d_word: got %0h, required %0h", k, out_data_o[k*DW +: DW], mon_exp);
                    end
                end
            end
        end
    end

    task automatic flush_q();
        for (int k = 0; k < N; k++) exp_q[k].delete();
    endtask

    function automatic int q_left();
        int r = 0;
        for (int k = 0; k < N; k++) r += exp_q[k].size();
        return r;
    endfunction

    // Called at posedge+1; leaves the job started and returns at posedge+1
    task automatic do_start(input logic [CW-1:0] len);
        start_i = 1'b1;
        len_i   = len;
        lane_m  = 0;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Offers words base..base+nw-1; accepted words are queued for their lane
    task automatic feed(input int nw, input int base, input bit wait_done, input int max_cyc,
                        output int done_cnt, output int last_v, output int done_c, output bit tmo);
        done_cnt = 0; last_v = -1; done_c = -1; tmo = 1'b1; cur_idx = 0;
        for (int c = 0; c < max_cyc; c++) begin
            in_valid_i = (cur_idx < nw);
            in_data_i  = DW'(base + cur_idx);
            @(negedge clk);
            if (out_valid_o != '0) last_v = c;
            if (done_o) begin done_cnt++; done_c = c; end
            if (in_valid_i && in_ready_o) begin
                exp_q[lane_m].push_back(in_data_i);
                lane_m = (lane_m + 1) % N;
                cur_idx++;
            end
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            if (wait_done ? (done_cnt > 0) : (cur_idx == nw)) begin tmo = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clear_i = 0; start_i = 0; len_i = '0;
        in_valid_i = 0; in_data_i = '0; out_ready_i = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({in_ready_o, busy_o, done_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, required 000", {in_ready_o, busy_o, done_o});
        end
        n_cmp++;
        if (out_valid_o !== '0) begin n_fail++; $display("FAIL reset_valid: got %h, required 0", out_valid_o); end
        n_cmp++;
        if (out_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", out_data_o); end
        n_cmp++;
        if (cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d, required 0", cnt_o); end
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        int dc, lv, dcy; bit tmo;
        out_ready_i = '1;
        do_start(16'd32);
        feed(32, 0, 1'b1, 500, dc, lv, dcy, tmo);
        n_cmp++;
        if (tmo) begin n_fail++; $display("FAIL basic_timeout: got timeout, required done"); end
        n_cmp++;
        if (dc != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d, required 1", dc); end
        n_cmp++;
        if (dcy - lv != 2) begin n_fail++; $display("FAIL basic_done_lat: got %0d, required 2", dcy - lv); end
        n_cmp++;
        if (cnt_o !== 16'd32) begin n_fail++; $display("FAIL basic_cnt: got %0d, required 32", cnt_o); end
        n_cmp++;
        if (q_left() != 0) begin n_fail++; $display("FAIL basic_left: got %0d, required 0", q_left()); end
    endtask

    task automatic test_backpressure();
        int dc, lv, dcy; bit tmo; bit seen;
        out_ready_i = ~16'h0008;
        do_start(16'd48);
        fork
            feed(48, 0, 1'b1, 2000, dc, lv, dcy, tmo);
            begin
                seen = 1'b0;
                for (int c = 0; c < 500; c++) begin
                    @(posedge clk); #2;
                    if (cur_idx == 35) begin seen = 1'b1; break; end
                end
                n_cmp++;
                if (!seen) begin n_fail++; $display("FAIL bp_reach35: got idx %0d, required 35", cur_idx); end
                repeat (4) @(posedge clk);
                #2;
                n_cmp++;
                if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, required 0", in_ready_o); end
                n_cmp++;
                if (cur_idx != 35) begin n_fail++; $display("FAIL bp_stall_idx: got %0d, required 35", cur_idx); end
                n_cmp++;
                if (out_valid_o[3] !== 1'b1 || out_data_o[3*DW +: DW] !== 32'd3) begin
                    n_fail++; $display("FAIL bp_lane3_head: got %b/%0h, required 1/3", out_valid_o[3], out_data_o[3*DW +: DW]);
                end
                out_ready_i[3] = 1'b1;
            end
        join
        n_cmp++;
        if (tmo || dc != 1) begin n_fail++; $display("FAIL bp_done: got tmo=%0d dc=%0d, required 0/1", tmo, dc); end
        n_cmp++;
        if (cnt_o !== 16'd48) begin n_fail++; $display("FAIL bp_cnt: got %0d, required 48", cnt_o); end
        n_cmp++;
        if (q_left() != 0) begin n_fail++; $display("FAIL bp_left: got %0d, required 0", q_left()); end
        out_ready_i = '1;
    endtask

    task automatic test_zero_len();
        out_ready_i = '1;
        do_start(16'd0);
        n_cmp++;
        if ({done_o, busy_o, in_ready_o} !== 3'b110) begin
            n_fail++; $display("FAIL zero_done: got %b, required 110", {done_o, busy_o, in_ready_o});
        end
        n_cmp++;
        if (cnt_o !== '0) begin n_fail++; $display("FAIL zero_cnt: got %0d, required 0", cnt_o); end
        @(posedge clk); #1;
        n_cmp++;
        if ({done_o, busy_o, in_ready_o} !== 3'b000) begin
            n_fail++; $display("FAIL zero_after: got %b, required 000", {done_o, busy_o, in_ready_o});
        end
    endtask

    task automatic test_push_pop();
        int dc, lv, dcy; bit tmo; bit seen;
        out_ready_i = ~16'h0001;
        do_start(16'd18);
        fork
            feed(18, 32'h100, 1'b1, 500, dc, lv, dcy, tmo);
            begin
                seen = 1'b0;
                for (int c = 0; c < 200; c++) begin
                    @(posedge clk); #2;
                    if (cur_idx == 16) begin seen = 1'b1; break; end
                end
                n_cmp++;
                if (!seen || out_valid_o[0] !== 1'b1 || in_ready_o !== 1'b1) begin
                    n_fail++; $display("FAIL pp_before: got seen=%0d v0=%b rdy=%b, required 1/1/1", seen, out_valid_o[0], in_ready_o);
                end
                out_ready_i[0] = 1'b1;
                @(posedge clk); #2;
                n_cmp++;
                if (out_valid_o[0] !== 1'b1 || out_data_o[DW-1:0] !== 32'h110) begin
                    n_fail++; $display("FAIL pp_after: got %b/%0h, required 1/110", out_valid_o[0], out_data_o[DW-1:0]);
                end
                n_cmp++;
                if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL pp_ready: got %b, required 1", in_ready_o); end
            end
        join
        n_cmp++;
        if (tmo || dc != 1 || q_left() != 0) begin
            n_fail++; $display("FAIL pp_end: got tmo=%0d dc=%0d left=%0d, required 0/1/0", tmo, dc, q_left());
        end
        out_ready_i = '1;
    endtask

    task automatic test_clear();
        int dc, lv, dcy; bit tmo;
        out_ready_i = '1;
        do_start(16'd100);
        feed(40, 32'h200, 1'b0, 500, dc, lv, dcy, tmo);
        n_cmp++;
        if (tmo || cnt_o !== 16'd40) begin n_fail++; $display("FAIL clr_pre: got tmo=%0d cnt=%0d, required 0/40", tmo, cnt_o); end
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        flush_q();
        n_cmp++;
        if (out_valid_o !== '0 || cnt_o !== '0 || busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL clr_post: got v=%h cnt=%0d busy=%b rdy=%b, required 0/0/0/0", out_valid_o, cnt_o, busy_o, in_ready_o);
        end
        clear_i = 1'b1; start_i = 1'b1; len_i = 16'd5;
        @(posedge clk); #1;
        clear_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clr_start: got busy %b, required 0", busy_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_async();
        int dc, lv, dcy; bit tmo;
        out_ready_i = '1;
        do_start(16'd100);
        feed(40, 32'h300, 1'b0, 500, dc, lv, dcy, tmo);
        n_cmp++;
        if (tmo || cnt_o !== 16'd40) begin n_fail++; $display("FAIL rst_pre: got tmo=%0d cnt=%0d, required 0/40", tmo, cnt_o); end
        @(negedge clk); #2;
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (out_valid_o !== '0 || cnt_o !== '0 || busy_o !== 1'b0 || in_ready_o !== 1'b0 || out_data_o !== '0) begin
            n_fail++; $display("FAIL rst_async: got v=%h cnt=%0d busy=%b rdy=%b, required 0/0/0/0", out_valid_o, cnt_o, busy_o, in_ready_o);
        end
        flush_q();
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_start_ignored();
        int dc, lv, dcy; bit tmo; int extra;
        out_ready_i = '1;
        do_start(16'd20);
        fork
            feed(20, 32'h400, 1'b1, 500, dc, lv, dcy, tmo);
            begin
                for (int c = 0; c < 200; c++) begin
                    @(posedge clk); #2;
                    if (cur_idx == 7) break;
                end
                start_i = 1'b1; len_i = 16'd5;
                @(posedge clk); #2;
                start_i = 1'b0;
            end
        join
        n_cmp++;
        if (tmo || dc != 1) begin n_fail++; $display("FAIL si_done: got tmo=%0d dc=%0d, required 0/1", tmo, dc); end
        n_cmp++;
        if (cnt_o !== 16'd20) begin n_fail++; $display("FAIL si_cnt: got %0d, required 20", cnt_o); end
        extra = 0;
        repeat (4) begin @(negedge clk); if (done_o) extra++; end
        n_cmp++;
        if (extra != 0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL si_extra: got dones=%0d busy=%b, required 0/0", extra, busy_o);
        end
        n_cmp++;
        if (q_left() != 0) begin n_fail++; $display("FAIL si_left: got %0d, required 0", q_left()); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_push_pop();
        test_clear();
        test_reset_async();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
